// File: rtl/decim_slicer.sv
// Decimator/slicer: picks one sample per OS enabled cycles at a programmable
// phase, registers it with its hard-decision bit, and counts symbols.
module decim_slicer #(
  parameter int NB_INPUT = 18,
  parameter int OS       = 4,
  parameter int NB_PHASE = 2,
  parameter int NB_CNT   = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_enable,
  input  logic        [NB_PHASE-1:0] i_phase,
  input  logic signed [NB_INPUT-1:0] i_data,
  output logic signed [NB_INPUT-1:0] o_data,
  output logic                       o_bit,
  output logic                       o_valid,
  output logic        [NB_CNT-1:0]   o_sym_count
);

  localparam logic [NB_PHASE-1:0] LAST_PHASE = NB_PHASE'(OS - 1);

  logic        [NB_PHASE-1:0] cnt_q, cnt_d;
  logic        [NB_PHASE-1:0] ph_q, ph_d;
  logic signed [NB_INPUT-1:0] data_q, data_d;
  logic                       bit_q, bit_d;
  logic                       valid_q, valid_d;
  logic        [NB_CNT-1:0]   sym_q, sym_d;
  logic                       frame_end;
  logic                       sample;

  assign frame_end = i_enable && (cnt_q == LAST_PHASE);
  // Compare against the phase held for the whole frame; a new i_phase only
  // lands at the frame boundary, so each frame samples exactly once.
  assign sample    = i_enable && (cnt_q == ph_q);

  always_comb begin
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    data_d  = data_q;
    bit_d   = bit_q;
    valid_d = 1'b0;
    sym_d   = sym_q;

    if (i_enable) begin
      cnt_d = frame_end ? '0 : cnt_q + 1'b1;
    end
    if (frame_end) begin
      ph_d = i_phase;
    end
    if (sample) begin
      data_d  = i_data;
      bit_d   = ~i_data[NB_INPUT-1];
      valid_d = 1'b1;
      if (sym_q != '1) begin
        sym_d = sym_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q   <= '0;
      ph_q    <= '0;
      data_q  <= '0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      sym_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      data_q  <= data_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      sym_q   <= sym_d;
    end
  end

  assign o_data      = data_q;
  assign o_bit       = bit_q;
  assign o_valid     = valid_q;
  assign o_sym_count = sym_q;

endmodule
